// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the instruction-side, data-side and physical memory signals
// of the two-to-one memory arbiter.
//   master modport : the arbiter's view (serves both requesters, drives memory strobes)
//   slave modport  : the environment's view (requesters plus physical memory)
// Signals:
//   i_read, i_address / i_rdata, i_resp                       instruction-side read port
//   d_read, d_write, d_byte_enable, d_address, d_wdata /
//   d_rdata, d_resp                                           data-side read/write port
//   mem_read, mem_write, mem_byte_enable, mem_address,
//   mem_wdata / mem_rdata, mem_resp                           physical memory port
interface mem_arbiter_if;
   logic        i_read;
   logic [31:0] i_address;
   logic [31:0] i_rdata;
   logic        i_resp;

   logic        d_read;
   logic        d_write;
   logic [3:0]  d_byte_enable;
   logic [31:0] d_address;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_resp;

   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;

   modport master (
      input  i_read, i_address,
      output i_rdata, i_resp,
      input  d_read, d_write, d_byte_enable, d_address, d_wdata,
      output d_rdata, d_resp,
      output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
      input  mem_rdata, mem_resp
   );

   modport slave (
      output i_read, i_address,
      input  i_rdata, i_resp,
      output d_read, d_write, d_byte_enable, d_address, d_wdata,
      input  d_rdata, d_resp,
      input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
      output mem_rdata, mem_resp
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one physical memory port between an
// instruction-side read port and a data-side read/write port.
// Ports:
//   clk  : single clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_arbiter_if.master carrying the I-side, D-side and memory signals
// Parameter:
//   I_FIRST : 1 = I-side wins the first tie after reset, 0 = D-side wins it
// Memory strobes, address, data and mask come straight from registers latched at grant,
// so there is no combinational path from requester inputs to the memory outputs.
module mem_arbiter #(
   parameter bit I_FIRST = 1'b1
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.master bus
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StBusyI = 2'd1;
   localparam logic [1:0] StBusyD = 2'd2;

   logic [1:0]  state_q, state_d;
   logic        last_i_q, last_i_d;  // 1 = most recent grant went to the I-side
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;

   logic i_pend;
   logic d_pend;

   assign i_pend = bus.i_read;
   assign d_pend = bus.d_read | bus.d_write;

   always_comb begin
      state_d  = state_q;
      last_i_d = last_i_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      case (state_q)
         StIdle: begin
            // On a tie, the side that did not win last time goes next.
            if (i_pend && (!d_pend || !last_i_q)) begin
               state_d  = StBusyI;
               last_i_d = 1'b1;
               addr_d   = bus.i_address;
               wdata_d  = 32'h0;
               be_d     = 4'hF;
               rd_d     = 1'b1;
               wr_d     = 1'b0;
            end else if (d_pend) begin
               state_d  = StBusyD;
               last_i_d = 1'b0;
               addr_d   = bus.d_address;
               if (bus.d_write) begin
                  // Write takes precedence when read and write are both raised.
                  wdata_d = bus.d_wdata;
                  be_d    = bus.d_byte_enable;
                  rd_d    = 1'b0;
                  wr_d    = 1'b1;
               end else begin
                  wdata_d = 32'h0;
                  be_d    = 4'hF;
                  rd_d    = 1'b1;
                  wr_d    = 1'b0;
               end
            end
         end
         StBusyI, StBusyD: begin
            if (bus.mem_resp) begin
               state_d = StIdle;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         last_i_q <= ~I_FIRST;  // pretend the other side won last so I_FIRST side wins the tie
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         be_q     <= 4'h0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_i_q <= last_i_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
      end
   end

   assign bus.mem_read        = rd_q;
   assign bus.mem_write       = wr_q;
   assign bus.mem_address     = addr_q;
   assign bus.mem_wdata       = wdata_q;
   assign bus.mem_byte_enable = be_q;

   assign bus.i_rdata = bus.mem_rdata;
   assign bus.d_rdata = bus.mem_rdata;

   // Reset abandons an in-flight transaction, so it also masks a same-cycle completion.
   assign bus.i_resp = (state_q == StBusyI) & bus.mem_resp & ~rst;
   assign bus.d_resp = (state_q == StBusyD) & bus.mem_resp & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (I_FIRST = 1).
// Inputs are driven and outputs sampled 1 ns or more after the rising edge.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter #(
      .I_FIRST (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, " mem_read"}, {31'h0, bus.mem_read}, 32'h0);
      check_eq({tag, " mem_write"}, {31'h0, bus.mem_write}, 32'h0);
      check_eq({tag, " mem_be"}, {28'h0, bus.mem_byte_enable}, 32'h0);
      check_eq({tag, " mem_addr"}, bus.mem_address, 32'h0);
      check_eq({tag, " mem_wdata"}, bus.mem_wdata, 32'h0);
      check_eq({tag, " i_resp"}, {31'h0, bus.i_resp}, 32'h0);
      check_eq({tag, " d_resp"}, {31'h0, bus.d_resp}, 32'h0);
   endtask

   // Starts in IDLE with requests already set: grant edge, completion, return to IDLE.
   task automatic serve(input string tag, input bit exp_d, input bit exp_wr,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_be, input logic [31:0] rdata);
      tick();
      check_eq({tag, " mem_read"}, {31'h0, bus.mem_read}, {31'h0, ~exp_wr});
      check_eq({tag, " mem_write"}, {31'h0, bus.mem_write}, {31'h0, exp_wr});
      check_eq({tag, " mem_addr"}, bus.mem_address, exp_addr);
      check_eq({tag, " mem_wdata"}, bus.mem_wdata, exp_wdata);
      check_eq({tag, " mem_be"}, {28'h0, bus.mem_byte_enable}, {28'h0, exp_be});
      check_eq({tag, " resp early"}, {30'h0, bus.i_resp, bus.d_resp}, 32'h0);
      bus.mem_rdata = rdata;
      bus.mem_resp  = 1'b1;
      #1;
      check_eq({tag, " i_resp"}, {31'h0, bus.i_resp}, {31'h0, ~exp_d});
      check_eq({tag, " d_resp"}, {31'h0, bus.d_resp}, {31'h0, exp_d});
      check_eq({tag, " rdata"}, exp_d ? bus.d_rdata : bus.i_rdata, rdata);
      tick();
      bus.mem_resp = 1'b0;
      #1;
      check_eq({tag, " strobes off"}, {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
      check_eq({tag, " resp off"}, {30'h0, bus.i_resp, bus.d_resp}, 32'h0);
   endtask

   initial begin
      rst               = 1'b1;
      bus.i_read        = 1'b0;
      bus.i_address     = 32'h0;
      bus.d_read        = 1'b0;
      bus.d_write       = 1'b0;
      bus.d_byte_enable = 4'h0;
      bus.d_address     = 32'h0;
      bus.d_wdata       = 32'h0;
      bus.mem_rdata     = 32'h0;
      bus.mem_resp      = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_all_zero("reset");

      // I-only read
      bus.i_read    = 1'b1;
      bus.i_address = 32'h60;
      serve("i_only", 1'b0, 1'b0, 32'h60, 32'h0, 4'hF, 32'hDEAD_BEEF);
      bus.i_read = 1'b0;

      // D write held over 5 wait cycles; address disturbed mid-transaction
      bus.d_write       = 1'b1;
      bus.d_address     = 32'h104;
      bus.d_wdata       = 32'h1234_5678;
      bus.d_byte_enable = 4'b0011;
      tick();
      for (int k = 0; k < 5; k++) begin
         check_eq("dwr mem_write", {31'h0, bus.mem_write}, 32'h1);
         check_eq("dwr mem_read", {31'h0, bus.mem_read}, 32'h0);
         check_eq("dwr mem_addr", bus.mem_address, 32'h104);
         check_eq("dwr mem_wdata", bus.mem_wdata, 32'h1234_5678);
         check_eq("dwr mem_be", {28'h0, bus.mem_byte_enable}, 32'h3);
         check_eq("dwr resp wait", {30'h0, bus.i_resp, bus.d_resp}, 32'h0);
         if (k == 1) begin
            bus.d_address = 32'hFFF0;
            bus.d_wdata   = 32'h0;
         end
         tick();
      end
      bus.mem_resp = 1'b1;
      #1;
      check_eq("dwr d_resp", {31'h0, bus.d_resp}, 32'h1);
      check_eq("dwr i_resp", {31'h0, bus.i_resp}, 32'h0);
      tick();
      bus.mem_resp = 1'b0;
      bus.d_write  = 1'b0;
      #1;
      check_eq("dwr d_resp pulse", {31'h0, bus.d_resp}, 32'h0);
      check_eq("dwr strobe off", {31'h0, bus.mem_write}, 32'h0);

      // Tie after a fresh reset: I, then D, then I while both stay requested
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.i_read    = 1'b1;
      bus.i_address = 32'h200;
      bus.d_read    = 1'b1;
      bus.d_address = 32'h300;
      serve("tie1 I", 1'b0, 1'b0, 32'h200, 32'h0, 4'hF, 32'h1111_0001);
      serve("tie2 D", 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 32'h2222_0002);
      serve("tie3 I", 1'b0, 1'b0, 32'h200, 32'h0, 4'hF, 32'h3333_0003);

      // Starvation: I held continuously, D write raised during BUSY_I
      bus.d_read = 1'b0;
      tick();
      check_eq("starve I mem_read", {31'h0, bus.mem_read}, 32'h1);
      check_eq("starve I mem_addr", bus.mem_address, 32'h200);
      bus.d_write       = 1'b1;
      bus.d_address     = 32'h400;
      bus.d_wdata       = 32'hA5A5_A5A5;
      bus.d_byte_enable = 4'hC;
      bus.mem_resp      = 1'b1;
      #1;
      check_eq("starve I i_resp", {31'h0, bus.i_resp}, 32'h1);
      check_eq("starve I d_resp", {31'h0, bus.d_resp}, 32'h0);
      tick();
      bus.mem_resp = 1'b0;
      serve("starve D", 1'b1, 1'b1, 32'h400, 32'hA5A5_A5A5, 4'hC, 32'h0);
      bus.i_read  = 1'b0;
      bus.d_write = 1'b0;

      // Reset during BUSY_D with a same-cycle completion
      bus.d_read    = 1'b1;
      bus.d_address = 32'h500;
      tick();
      check_eq("rstbusy mem_read", {31'h0, bus.mem_read}, 32'h1);
      check_eq("rstbusy mem_addr", bus.mem_address, 32'h500);
      rst          = 1'b1;
      bus.mem_resp = 1'b1;
      #1;
      check_eq("rstbusy d_resp", {31'h0, bus.d_resp}, 32'h0);
      tick();
      rst          = 1'b0;
      bus.mem_resp = 1'b0;
      bus.d_read   = 1'b0;
      #1;
      check_all_zero("rstbusy after");

      // Stray completion in IDLE, then a normal request still gets granted next cycle
      bus.mem_resp = 1'b1;
      #1;
      check_eq("stray resp", {30'h0, bus.i_resp, bus.d_resp}, 32'h0);
      tick();
      bus.mem_resp = 1'b0;
      #1;
      check_eq("stray strobes", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
      bus.i_read    = 1'b1;
      bus.i_address = 32'h7C;
      serve("post stray I", 1'b0, 1'b0, 32'h7C, 32'h0, 4'hF, 32'hCAFE_F00D);
      bus.i_read = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: I_FIRST, default 1, round-robin priority after reset (1 = I-side wins first tie, 0 = D-side).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_read  input  1  instruction-side read request, held until i_resp.
REQ-005 i_address  input  32  instruction-side byte address.
REQ-006 i_rdata  output  32  instruction-side read data.
REQ-007 i_resp  output  1  instruction-side completion, one-cycle pulse.
REQ-008 d_read  input  1  data-side read request, held until d_resp.
REQ-009 d_write  input  1  data-side write request, held until d_resp.
REQ-010 d_byte_enable  input  4  data-side write byte mask.
REQ-011 d_address  input  32  data-side byte address.
REQ-012 d_wdata  input  32  data-side write data.
REQ-013 d_rdata  output  32  data-side read data.
REQ-014 d_resp  output  1  data-side completion, one-cycle pulse.
REQ-015 mem_read  output  1  physical memory read strobe, held until mem_resp.
REQ-016 mem_write  output  1  physical memory write strobe, held until mem_resp.
REQ-017 mem_byte_enable  output  4  physical memory byte mask.
REQ-018 mem_address  output  32  physical memory address.
REQ-019 mem_wdata  output  32  physical memory write data.
REQ-020 mem_rdata  input  32  physical memory read data, valid with mem_resp.
REQ-021 mem_resp  input  1  physical memory completion, one-cycle pulse.

Function
REQ-022 States: IDLE, BUSY_I, BUSY_D; exactly one state active.
REQ-023 IDLE: pending = i_read (I) / d_read|d_write (D); none pending -> stay IDLE.
REQ-024 IDLE, one pending -> grant it; both pending -> grant side opposite last_grant.
REQ-025 last_grant: 1 bit, updated to granted side at grant; reset value selects so I_FIRST side wins first tie.
REQ-026 Grant cycle latches address, wdata, byte_enable, op (read/write) into registers; mem_* driven only from these registers.
REQ-027 Latency: request sampled in IDLE at edge N -> mem_read/mem_write asserted in cycle N+1; no combinational path from i_*/d_* inputs to mem_* outputs.
REQ-028 I grant: mem_read=1, mem_write=0, mem_byte_enable=4'hF, mem_wdata=0.
REQ-029 D grant: d_write=1 -> mem_write=1, mem_read=0 (write wins if both set); else mem_read=1; mem_byte_enable=d_byte_enable for write, 4'hF for read.
REQ-030 BUSY_x: strobes held constant until mem_resp=1; on that cycle x_resp=1 combinationally, next state IDLE, strobes deassert next cycle.
REQ-031 i_rdata and d_rdata SHALL equal mem_rdata at all times; responses only on granted side.
REQ-032 Non-granted side: resp=0; request stays pending, served no later than after one granted transaction of the other side (no starvation).
REQ-033 Requester dropping request mid-BUSY: transaction completes using latched values; resp still pulsed.
REQ-034 mem_resp in IDLE: ignored; no resp pulsed, no state change.
REQ-035 Minimum one IDLE cycle between consecutive transactions (back-to-back grants 2 cycles apart min).

Reset
REQ-036 rst=1 at edge: state=IDLE, last_grant per I_FIRST, latched registers=0, mem_read=mem_write=0, mem_byte_enable=0, mem_address=0, mem_wdata=0, i_resp=d_resp=0.
REQ-037 rst during BUSY_x: transaction abandoned, no resp pulsed, IDLE next cycle; rst dominates mem_resp same cycle.

Verification
REQ-038 I-only: i_read=1, i_address=0x60 in IDLE -> next cycle mem_read=1, mem_address=0x60; mem_resp with mem_rdata=0xDEADBEEF -> same cycle i_resp=1, i_rdata=0xDEADBEEF, d_resp=0.
REQ-039 D write: d_write=1, d_address=0x104, d_wdata=0x12345678, d_byte_enable=4'b0011 -> mem_write=1, mem_read=0, mem_* match, held across 5 wait cycles until mem_resp -> d_resp one pulse.
REQ-040 Tie after reset (I_FIRST=1): i_read and d_read asserted same cycle, held -> I served first, then D; repeat tie -> order alternates D before I on the round after last_grant=I.
REQ-041 Starvation: I requests continuously, D asserted once -> D granted immediately after current I transaction completes.
REQ-042 Mid-op disturbance: change d_address during BUSY_D -> mem_address unchanged; assert rst during BUSY_D with mem_resp=1 -> no d_resp, all outputs zero next cycle.
REQ-043 Stray mem_resp in IDLE with no requests -> no resp outputs, state remains IDLE.
